// File: rtl/video_timing_pkg.sv
// Shared types and presets for the raster timing generator.
//   CNT_W        : width of every timing field and counter
//   axis_cfg_t   : {total, sync, bporch, res} for one axis
//   *_800X600, *_1024X768, *_1280X720 : standard per-axis presets
//   cfg_axis_valid() : legality check applied to a requested axis config
package video_timing_pkg;

  localparam int unsigned CNT_W = 12;

  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] sync;
    logic [CNT_W-1:0] bporch;
    logic [CNT_W-1:0] res;
  } axis_cfg_t;

  localparam axis_cfg_t H_800X600  = '{total: CNT_W'(1056), sync: CNT_W'(128), bporch: CNT_W'(88),  res: CNT_W'(800)};
  localparam axis_cfg_t V_800X600  = '{total: CNT_W'(628),  sync: CNT_W'(4),   bporch: CNT_W'(23),  res: CNT_W'(600)};
  localparam axis_cfg_t H_1024X768 = '{total: CNT_W'(1344), sync: CNT_W'(136), bporch: CNT_W'(160), res: CNT_W'(1024)};
  localparam axis_cfg_t V_1024X768 = '{total: CNT_W'(806),  sync: CNT_W'(6),   bporch: CNT_W'(29),  res: CNT_W'(768)};
  localparam axis_cfg_t H_1280X720 = '{total: CNT_W'(1650), sync: CNT_W'(40),  bporch: CNT_W'(220), res: CNT_W'(1280)};
  localparam axis_cfg_t V_1280X720 = '{total: CNT_W'(750),  sync: CNT_W'(5),   bporch: CNT_W'(20),  res: CNT_W'(720)};

  // Every field nonzero and sync+bporch+res fits inside total. The partial
  // sum is checked first, so a CNT_W+1 accumulator never overflows on a
  // config that is accepted.
  function automatic logic cfg_axis_valid(input axis_cfg_t c);
    logic [CNT_W:0] lead;
    logic [CNT_W:0] span;
    lead = {1'b0, c.sync} + {1'b0, c.bporch};
    span = lead + {1'b0, c.res};
    return (c.total != '0) && (c.sync != '0) && (c.bporch != '0) && (c.res != '0) &&
           (lead <= {1'b0, c.total}) && (span <= {1'b0, c.total});
  endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// One raster axis: position counter plus sync/active decode.
//   clk, rst_n     : clock, async active-low reset
//   cfg            : active axis timing
//   step           : advance the counter this cycle
//   clr            : force the counter to 0 (wins over step)
//   cnt            : registered position
//   wrap_c         : step on the last position (counter returns to 0)
//   sync_act_c     : position inside the sync pulse
//   active_act_c   : position inside the active window
//   coord_c        : offset into the active window, 0 outside it
module timing_axis_cnt
  import video_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  axis_cfg_t        cfg,
  input  logic             step,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_c,
  output logic             sync_act_c,
  output logic             active_act_c,
  output logic [CNT_W-1:0] coord_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_c;
  logic [CNT_W:0]   win_lo;
  logic [CNT_W:0]   win_hi;

  // Decode and next-count; >= on the last position keeps the counter bounded.
  always_comb begin
    last_c       = (cnt_q >= (cfg.total - CNT_W'(1)));
    win_lo       = {1'b0, cfg.sync} + {1'b0, cfg.bporch};
    win_hi       = win_lo + {1'b0, cfg.res};
    wrap_c       = step & last_c;
    sync_act_c   = (cnt_q < cfg.sync);
    active_act_c = ({1'b0, cnt_q} >= win_lo) && ({1'b0, cnt_q} < win_hi);
    coord_c      = '0;
    if (active_act_c) begin
      coord_c = cnt_q - win_lo[CNT_W-1:0];
    end
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = last_c ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator (DE/HS/VS, x/y, SOF/SOL).
//   I_pxl_clk, I_rst_n      : pixel clock, async active-low reset
//   I_enable                : run (1) / hold counters at 0,0 (0)
//   I_cfg_load              : capture I_h_*, I_v_*, I_*_pol into the shadow
//   I_h_*, I_v_*, I_*_pol   : requested timing
//   O_de, O_hs, O_vs        : registered video timing
//   O_x, O_y                : active-area coordinates (0 outside DE)
//   O_sof, O_sol            : first pixel of frame / of each active line
//   O_cfg_pend, O_cfg_err   : shadow waiting for frame boundary / last load rejected
module video_timing_gen #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned DEF_H_TOTAL = 1650,
  parameter int unsigned DEF_H_SYNC  = 40,
  parameter int unsigned DEF_H_BPORCH = 220,
  parameter int unsigned DEF_H_RES   = 1280,
  parameter int unsigned DEF_V_TOTAL = 750,
  parameter int unsigned DEF_V_SYNC  = 5,
  parameter int unsigned DEF_V_BPORCH = 20,
  parameter int unsigned DEF_V_RES   = 720,
  parameter logic        DEF_HS_POL  = 1'b1,
  parameter logic        DEF_VS_POL  = 1'b1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_enable,
  input  logic             I_cfg_load,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  input  logic             I_hs_pol,
  input  logic             I_vs_pol,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_sof,
  output logic             O_sol,
  output logic             O_cfg_pend,
  output logic             O_cfg_err
);

  import video_timing_pkg::*;

  localparam int unsigned FW = $bits(axis_cfg_t) / 4;

  localparam axis_cfg_t DEF_H = '{total: FW'(DEF_H_TOTAL), sync: FW'(DEF_H_SYNC),
                                  bporch: FW'(DEF_H_BPORCH), res: FW'(DEF_H_RES)};
  localparam axis_cfg_t DEF_V = '{total: FW'(DEF_V_TOTAL), sync: FW'(DEF_V_SYNC),
                                  bporch: FW'(DEF_V_BPORCH), res: FW'(DEF_V_RES)};

  // Active / shadow configuration
  axis_cfg_t act_h_q, act_h_d, act_v_q, act_v_d;
  axis_cfg_t shd_h_q, shd_h_d, shd_v_q, shd_v_d;
  logic      act_hs_pol_q, act_hs_pol_d, act_vs_pol_q, act_vs_pol_d;
  logic      shd_hs_pol_q, shd_hs_pol_d, shd_vs_pol_q, shd_vs_pol_d;
  logic      pend_q, pend_d, err_q, err_d;

  // Output registers
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             sof_q, sof_d, sol_q, sol_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  // Axis counter results
  logic [FW-1:0] h_cnt, v_cnt, h_coord, v_coord;
  logic          h_wrap, v_wrap, h_sync_act, v_sync_act, h_act, v_act;

  axis_cfg_t cand_h, cand_v;
  logic      cand_ok, apply;

  timing_axis_cnt u_h_cnt (
    .clk          (I_pxl_clk),
    .rst_n        (I_rst_n),
    .cfg          (act_h_q),
    .step         (I_enable),
    .clr          (~I_enable),
    .cnt          (h_cnt),
    .wrap_c       (h_wrap),
    .sync_act_c   (h_sync_act),
    .active_act_c (h_act),
    .coord_c      (h_coord)
  );

  timing_axis_cnt u_v_cnt (
    .clk          (I_pxl_clk),
    .rst_n        (I_rst_n),
    .cfg          (act_v_q),
    .step         (h_wrap),
    .clr          (~I_enable),
    .cnt          (v_cnt),
    .wrap_c       (v_wrap),
    .sync_act_c   (v_sync_act),
    .active_act_c (v_act),
    .coord_c      (v_coord)
  );

  // Shadow capture, frame-boundary apply, and output decode.
  always_comb begin
    cand_h  = '{total: FW'(I_h_total), sync: FW'(I_h_sync), bporch: FW'(I_h_bporch), res: FW'(I_h_res)};
    cand_v  = '{total: FW'(I_v_total), sync: FW'(I_v_sync), bporch: FW'(I_v_bporch), res: FW'(I_v_res)};
    cand_ok = cfg_axis_valid(cand_h) && cfg_axis_valid(cand_v);
    // v_wrap implies h_wrap: last pixel of the frame. Disabled counters sit
    // at 0,0 so a pending config can be taken without tearing anything.
    apply   = pend_q & (v_wrap | ~I_enable);

    act_h_d      = act_h_q;
    act_v_d      = act_v_q;
    act_hs_pol_d = act_hs_pol_q;
    act_vs_pol_d = act_vs_pol_q;
    shd_h_d      = shd_h_q;
    shd_v_d      = shd_v_q;
    shd_hs_pol_d = shd_hs_pol_q;
    shd_vs_pol_d = shd_vs_pol_q;
    pend_d       = pend_q;
    err_d        = err_q;

    // Apply uses the old shadow; a load in the same cycle queues behind it.
    if (apply) begin
      act_h_d      = shd_h_q;
      act_v_d      = shd_v_q;
      act_hs_pol_d = shd_hs_pol_q;
      act_vs_pol_d = shd_vs_pol_q;
      pend_d       = 1'b0;
    end
    if (I_cfg_load) begin
      if (cand_ok) begin
        shd_h_d      = cand_h;
        shd_v_d      = cand_v;
        shd_hs_pol_d = I_hs_pol;
        shd_vs_pol_d = I_vs_pol;
        pend_d       = 1'b1;
        err_d        = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    de_d  = I_enable & h_act & v_act;
    x_d   = de_d ? CNT_W'(h_coord) : '0;
    y_d   = de_d ? CNT_W'(v_coord) : '0;
    sol_d = de_d & (h_coord == '0);
    sof_d = sol_d & (v_coord == '0);
    hs_d  = I_enable ? ~(h_sync_act ^ act_hs_pol_q) : ~act_hs_pol_q;
    vs_d  = I_enable ? ~(v_sync_act ^ act_vs_pol_q) : ~act_vs_pol_q;
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      act_h_q      <= DEF_H;
      act_v_q      <= DEF_V;
      act_hs_pol_q <= DEF_HS_POL;
      act_vs_pol_q <= DEF_VS_POL;
      shd_h_q      <= DEF_H;
      shd_v_q      <= DEF_V;
      shd_hs_pol_q <= DEF_HS_POL;
      shd_vs_pol_q <= DEF_VS_POL;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= ~DEF_HS_POL;
      vs_q         <= ~DEF_VS_POL;
      x_q          <= '0;
      y_q          <= '0;
      sof_q        <= 1'b0;
      sol_q        <= 1'b0;
    end else begin
      act_h_q      <= act_h_d;
      act_v_q      <= act_v_d;
      act_hs_pol_q <= act_hs_pol_d;
      act_vs_pol_q <= act_vs_pol_d;
      shd_h_q      <= shd_h_d;
      shd_v_q      <= shd_v_d;
      shd_hs_pol_q <= shd_hs_pol_d;
      shd_vs_pol_q <= shd_vs_pol_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sof_q        <= sof_d;
      sol_q        <= sol_d;
    end
  end

  assign O_de       = de_q;
  assign O_hs       = hs_q;
  assign O_vs       = vs_q;
  assign O_x        = x_q;
  assign O_y        = y_q;
  assign O_sof      = sof_q;
  assign O_sol      = sol_q;
  assign O_cfg_pend = pend_q;
  assign O_cfg_err  = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: reset values, default-mode first line
// and first SOF, a table of load/validate/measure-one-frame vectors, and
// hand sequences for boundary apply, double load, load-on-wrap, disable,
// and asynchronous reset.
module tb_video_timing_gen;

  typedef struct {
    int unsigned ht, hsy, hbp, hr;
    int unsigned vt, vsy, vbp, vr;
    bit          hp, vp;
    bit          exp_err;
    // expected frame once this (or the retained) config is active
    int unsigned per;
    bit          apol;
    int unsigned de, first, hsn, xmax, ymax, sol;
  } vec_t;

  localparam int NV = 8;

  logic        clk, rst_n, enable, cfg_load;
  logic [11:0] h_total, h_sync, h_bporch, h_res;
  logic [11:0] v_total, v_sync, v_bporch, v_res;
  logic        hs_pol, vs_pol;
  logic        de, hs, vs, sof, sol, pend, err;
  logic [11:0] x, y;

  int checks = 0;
  int failures = 0;
  vec_t vecs [NV];

  video_timing_gen dut (
    .I_pxl_clk (clk),      .I_rst_n   (rst_n),
    .I_enable  (enable),   .I_cfg_load(cfg_load),
    .I_h_total (h_total),  .I_h_sync  (h_sync),
    .I_h_bporch(h_bporch), .I_h_res   (h_res),
    .I_v_total (v_total),  .I_v_sync  (v_sync),
    .I_v_bporch(v_bporch), .I_v_res   (v_res),
    .I_hs_pol  (hs_pol),   .I_vs_pol  (vs_pol),
    .O_de      (de),       .O_hs      (hs),
    .O_vs      (vs),       .O_x       (x),
    .O_y       (y),        .O_sof     (sof),
    .O_sol     (sol),      .O_cfg_pend(pend),
    .O_cfg_err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    h_total = 12'(v.ht);  h_sync = 12'(v.hsy); h_bporch = 12'(v.hbp); h_res = 12'(v.hr);
    v_total = 12'(v.vt);  v_sync = 12'(v.vsy); v_bporch = 12'(v.vbp); v_res = 12'(v.vr);
    hs_pol  = v.hp;       vs_pol = v.vp;
  endtask

  task automatic load(input vec_t v);
    drive_cfg(v);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s flags", tag), 32'({de, hs, vs, sof, sol, pend, err}), 32'd0);
    check($sformatf("%s xy", tag), 32'({x, y}), 32'd0);
  endtask

  // Samples one full frame starting at counter position 0.
  task automatic measure(input vec_t e, input string tag);
    int de_n, sof_n, sol_n, hs_n, first, xmax, ymax, bad;
    de_n = 0; sof_n = 0; sol_n = 0; hs_n = 0; first = -1; xmax = 0; ymax = 0; bad = 0;
    for (int t = 0; t < int'(e.per); t++) begin
      tick();
      if (de) begin
        de_n++;
        if (first < 0) first = t;
        if (int'(x) > xmax) xmax = int'(x);
        if (int'(y) > ymax) ymax = int'(y);
      end else if (x != 12'd0 || y != 12'd0) begin
        bad++;
      end
      if (sof) begin
        sof_n++;
        if (!(de && x == 12'd0 && y == 12'd0)) bad++;
      end
      if (sol) begin
        sol_n++;
        if (!(de && x == 12'd0)) bad++;
      end
      if (hs == e.apol) hs_n++;
    end
    check($sformatf("%s de_count", tag), 32'(de_n), 32'(e.de));
    check($sformatf("%s first_de", tag), 32'(first), 32'(e.first));
    check($sformatf("%s hs_active", tag), 32'(hs_n), 32'(e.hsn));
    check($sformatf("%s x_max", tag), 32'(xmax), 32'(e.xmax));
    check($sformatf("%s y_max", tag), 32'(ymax), 32'(e.ymax));
    check($sformatf("%s sof_count", tag), 32'(sof_n), 32'd1);
    check($sformatf("%s sol_count", tag), 32'(sol_n), 32'(e.sol));
    check($sformatf("%s strobe_coherence", tag), 32'(bad), 32'd0);
  endtask

  initial begin
    int first, hs_hi, waited, bad;
    logic vs_start, vs_after, sof_at, sol_at;
    logic [23:0] xy_at;

    //            ht   hsy  hbp  hr    vt   vsy  vbp  vr   hp vp err  per apol de first hsn xmax ymax sol
    vecs[0] = '{10,  2,   2,   4,    6,   1,   1,   3,   0, 0, 0,   60, 0,  12, 24,  12, 3,  2,  3};
    vecs[1] = '{20,  8,   8,   8,    6,   1,   1,   3,   1, 1, 1,   60, 0,  12, 24,  12, 3,  2,  3};
    vecs[2] = '{16,  3,   5,   6,    10,  2,   3,   4,   1, 0, 0,  160, 1,  24, 88,  30, 5,  3,  4};
    vecs[3] = '{10,  0,   2,   4,    6,   1,   1,   3,   0, 0, 1,  160, 1,  24, 88,  30, 5,  3,  4};
    vecs[4] = '{8,   1,   1,   6,    5,   1,   1,   3,   1, 1, 0,   40, 1,  18, 18,   5, 5,  2,  3};
    vecs[5] = '{4095,4095,4095,4095, 4095,4095,4095,4095, 0, 0, 1, 40, 1,  18, 18,   5, 5,  2,  3};
    vecs[6] = '{8,   1,   1,   7,    5,   1,   1,   3,   0, 0, 1,   40, 1,  18, 18,   5, 5,  2,  3};
    vecs[7] = '{8,   1,   1,   6,    5,   1,   1,   4,   1, 1, 1,   40, 1,  18, 18,   5, 5,  2,  3};

    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    drive_cfg(vecs[0]);
    #22;
    check_reset_vals("reset");

    // Default 1280x720 mode from reset: first line sync, then first DE/SOF.
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    first = -1; hs_hi = 0; vs_start = 1'b0; vs_after = 1'b1;
    sof_at = 1'b0; sol_at = 1'b0; xy_at = '1;
    for (int idx = 0; idx < 50000 && first < 0; idx++) begin
      tick();
      if (idx < 1650 && hs) hs_hi++;
      if (idx == 0) vs_start = vs;
      if (idx == 5 * 1650) vs_after = vs;
      if (de) begin
        first = idx; sof_at = sof; sol_at = sol; xy_at = {x, y};
      end
    end
    check("def hs_high_line0", 32'(hs_hi), 32'd40);
    check("def vs_line0", 32'(vs_start), 32'd1);
    check("def vs_line5", 32'(vs_after), 32'd0);
    check("def first_de", 32'(first), 32'd41510);
    check("def first_sof", 32'({sof_at, sol_at}), 32'd3);
    check("def first_xy", 32'(xy_at), 32'd0);
    tick();
    check("def second_x", 32'(x), 32'd1);

    // Table: load while disabled, check validation, measure one frame.
    for (int i = 0; i < NV; i++) begin
      enable = 1'b0;
      tick();
      load(vecs[i]);
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d pend", i), 32'(pend), 32'(!vecs[i].exp_err));
      tick();
      check($sformatf("vec%0d pend_applied", i), 32'(pend), 32'd0);
      enable = 1'b1;
      measure(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-frame load waits for the end of the running (40-cycle) frame.
    repeat (10) tick();
    load(vecs[2]);
    check("mid pend", 32'({pend, err}), 32'b10);
    waited = 0;
    while (pend === 1'b1 && waited < 1000) begin tick(); waited++; end
    check("mid wait_to_boundary", 32'(waited), 32'd29);
    measure(vecs[2], "mid");

    // Two loads in one frame: only the second reaches the active config.
    repeat (5) tick();
    load(vecs[0]);
    repeat (3) tick();
    check("dbl pend_first", 32'(pend), 32'd1);
    load(vecs[4]);
    waited = 0;
    while (pend === 1'b1 && waited < 1000) begin tick(); waited++; end
    check("dbl wait_to_boundary", 32'(waited), 32'd150);
    measure(vecs[4], "dbl");

    // Load on the exact wrap cycle of the 40-cycle frame.
    repeat (5) tick();
    load(vecs[2]);
    repeat (33) tick();
    load(vecs[0]);
    check("wrap pend_kept", 32'(pend), 32'd1);
    measure(vecs[2], "wrap_first");
    check("wrap pend_cleared", 32'(pend), 32'd0);
    measure(vecs[0], "wrap_second");

    // Disable for 100 cycles mid-line; mode has HS/VS active-low.
    repeat (3) tick();
    enable = 1'b0;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (de || sof || sol || hs !== 1'b1 || vs !== 1'b1 || x != 12'd0 || y != 12'd0) bad++;
    end
    check("dis inactive_cycles", 32'(bad), 32'd0);
    enable = 1'b1;
    measure(vecs[0], "reen");

    // Pending valid load survives a rejected load, then async reset mid-DE.
    load(vecs[2]);
    load(vecs[1]);
    check("rst pend_err", 32'({pend, err}), 32'b11);
    waited = 0;
    while (de !== 1'b1 && waited < 100) begin tick(); waited++; end
    check("rst reached_de", 32'(de), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    hs_hi = 0; bad = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (hs) hs_hi++;
      if (de) bad++;
    end
    check("post_rst hs_high", 32'(hs_hi), 32'd40);
    check("post_rst no_de", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
